// File: rtl/debounce_bank.sv
// debounce_bank: CH-channel key/switch debouncer.
// Each channel synchronises its raw input (optionally inverted for active-low
// keys), filters it to a stable level, and emits registered one-cycle pulses
// on press (rise), release (fall) and once per press after a long hold.
module debounce_bank #(
   parameter int unsigned CH       = 4,
   parameter int unsigned T_STABLE = 8,
   parameter int unsigned CNT_W    = 20,
   parameter int unsigned T_LONG   = 32,
   parameter int unsigned LONG_W   = 26,
   parameter bit          INVERT   = 1'b0,
   parameter logic        D_INIT   = 1'b0
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic [CH-1:0] din,
   output logic [CH-1:0] dout,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic [CH-1:0] long_pulse
);

   localparam logic [CNT_W-1:0]  CNT_TERM  = CNT_W'(T_STABLE - 1);
   localparam logic [LONG_W-1:0] LONG_TERM = LONG_W'(T_LONG - 1);
   localparam logic [CH-1:0]     INV_MASK  = {CH{INVERT}};
   localparam logic [CH-1:0]     INIT_VEC  = {CH{D_INIT}};

   logic [CH-1:0]     s1_q, s1_d;
   logic [CH-1:0]     s2_q, s2_d;
   logic [CH-1:0]     dout_q, dout_d;
   logic [CH-1:0]     rise_q, rise_d;
   logic [CH-1:0]     fall_q, fall_d;
   logic [CH-1:0]     long_q, long_d;
   logic [CH-1:0]     done_q, done_d;
   logic [CNT_W-1:0]  cnt_q  [CH];
   logic [CNT_W-1:0]  cnt_d  [CH];
   logic [LONG_W-1:0] hcnt_q [CH];
   logic [LONG_W-1:0] hcnt_d [CH];

   // Next-state: synchroniser, stability filter and long-press hold logic per channel.
   always_comb begin
      s1_d   = din ^ INV_MASK;
      s2_d   = s1_q;
      dout_d = dout_q;
      done_d = done_q;
      rise_d = '0;
      fall_d = '0;
      long_d = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         cnt_d[i]  = cnt_q[i];
         hcnt_d[i] = hcnt_q[i];

         if (s2_q[i] == dout_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] != CNT_TERM) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else begin
            dout_d[i] = s2_q[i];
            cnt_d[i]  = '0;
            rise_d[i] = s2_q[i];
            fall_d[i] = ~s2_q[i];
         end

         if (!dout_q[i]) begin
            hcnt_d[i] = '0;
            done_d[i] = 1'b0;
         end else if (!done_q[i]) begin
            if (hcnt_q[i] != LONG_TERM) begin
               hcnt_d[i] = hcnt_q[i] + LONG_W'(1);
            end else begin
               long_d[i] = 1'b1;
               done_d[i] = 1'b1;
            end
         end
      end
   end

   // State registers with synchronous active-low reset; reset discards all progress.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         s1_q   <= INIT_VEC;
         s2_q   <= INIT_VEC;
         dout_q <= INIT_VEC;
         rise_q <= '0;
         fall_q <= '0;
         long_q <= '0;
         done_q <= '0;
         for (int unsigned i = 0; i < CH; i++) begin
            cnt_q[i]  <= '0;
            hcnt_q[i] <= '0;
         end
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         long_q <= long_d;
         done_q <= done_d;
         for (int unsigned i = 0; i < CH; i++) begin
            cnt_q[i]  <= cnt_d[i];
            hcnt_q[i] <= hcnt_d[i];
         end
      end
   end

   assign dout       = dout_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign long_pulse = long_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: default instance plus an inverted,
// D_INIT=1 instance driven from the same clock and reset.
module tb_debounce_bank;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [3:0] din_a, din_b;
   logic [3:0] dout_a, rise_a, fall_a, long_a;
   logic [3:0] dout_b, rise_b, fall_b, long_b;

   int checks   = 0;
   int failures = 0;
   int nlong;

   debounce_bank u_a (
      .clk        (clk),
      .n_rst      (n_rst),
      .din        (din_a),
      .dout       (dout_a),
      .rise       (rise_a),
      .fall       (fall_a),
      .long_pulse (long_a)
   );

   debounce_bank #(.INVERT(1'b1), .D_INIT(1'b1)) u_b (
      .clk        (clk),
      .n_rst      (n_rst),
      .din        (din_b),
      .dout       (dout_b),
      .rise       (rise_b),
      .fall       (fall_b),
      .long_pulse (long_b)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, leaving the bench 1 time unit after the last edge.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset with all inputs high
      n_rst = 1'b0;
      din_a = 4'hF;
      din_b = 4'hF;
      tick(3);
      check("rst_dout_a", 32'(dout_a), 32'h0);
      check("rst_rise_a", 32'(rise_a), 32'h0);
      check("rst_fall_a", 32'(fall_a), 32'h0);
      check("rst_long_a", 32'(long_a), 32'h0);
      check("rst_dout_b", 32'(dout_b), 32'hF);

      n_rst = 1'b1;
      tick(9);
      check("rst_settle_early_a", 32'(dout_a), 32'h0);
      tick(1);
      check("rst_settle_dout_a", 32'(dout_a), 32'hF);
      check("rst_settle_rise_a", 32'(rise_a), 32'hF);
      check("inv_idle_dout_b", 32'(dout_b), 32'h0);
      check("inv_idle_fall_b", 32'(fall_b), 32'hF);
      tick(1);
      check("rst_settle_rise_clr", 32'(rise_a), 32'h0);
      din_a = 4'h0;
      tick(10);
      check("rst_release_dout", 32'(dout_a), 32'h0);
      check("rst_release_fall", 32'(fall_a), 32'hF);
      tick(3);

      // Clean press on channel 0
      din_a = 4'h1;
      tick(9);
      check("press_early", 32'(dout_a), 32'h0);
      tick(1);
      check("press_dout", 32'(dout_a), 32'h1);
      check("press_rise", 32'(rise_a), 32'h1);
      tick(1);
      check("press_rise_once", 32'(rise_a), 32'h0);
      tick(9);
      din_a = 4'h0;
      tick(9);
      check("release_early", 32'(dout_a), 32'h1);
      tick(1);
      check("release_dout", 32'(dout_a), 32'h0);
      check("release_fall", 32'(fall_a), 32'h1);
      tick(1);
      check("release_fall_once", 32'(fall_a), 32'h0);
      tick(2);

      // Glitch of 7 cycles rejected, 8 cycles accepted on channel 1
      din_a = 4'h2;
      tick(7);
      din_a = 4'h0;
      tick(3);
      check("glitch7_dout", 32'(dout_a), 32'h0);
      check("glitch7_rise", 32'(rise_a), 32'h0);
      tick(5);
      check("glitch7_dout_late", 32'(dout_a), 32'h0);
      din_a = 4'h2;
      tick(8);
      din_a = 4'h0;
      tick(1);
      check("pulse8_early", 32'(dout_a), 32'h0);
      tick(1);
      check("pulse8_dout", 32'(dout_a), 32'h2);
      check("pulse8_rise", 32'(rise_a), 32'h2);
      tick(7);
      check("pulse8_hold", 32'(dout_a), 32'h2);
      tick(1);
      check("pulse8_fall_dout", 32'(dout_a), 32'h0);
      check("pulse8_fall", 32'(fall_a), 32'h2);
      tick(2);

      // Long press on channel 2 held 60 cycles
      din_a = 4'h4;
      nlong = 0;
      for (int k = 1; k <= 60; k++) begin
         tick(1);
         if (long_a[2]) nlong++;
         if (k == 10) check("long_rise", 32'(rise_a), 32'h4);
         if (k == 41) check("long_early", 32'(long_a), 32'h0);
         if (k == 42) check("long_pulse", 32'(long_a), 32'h4);
         if (k == 43) check("long_pulse_once", 32'(long_a), 32'h0);
      end
      din_a = 4'h0;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         if (long_a[2]) nlong++;
         if (k == 10) check("long_release_fall", 32'(fall_a), 32'h4);
      end
      check("long_count", 32'(nlong), 32'd1);

      // Short 20-cycle press gives no long pulse
      din_a = 4'h4;
      nlong = 0;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (long_a[2]) nlong++;
      end
      din_a = 4'h0;
      for (int k = 1; k <= 40; k++) begin
         tick(1);
         if (long_a[2]) nlong++;
      end
      check("short_no_long", 32'(nlong), 32'd0);
      check("short_dout", 32'(dout_a), 32'h0);

      // Channels 0 and 3 pressed together
      din_a = 4'h9;
      tick(10);
      check("indep_dout", 32'(dout_a), 32'h9);
      check("indep_rise", 32'(rise_a), 32'h9);
      din_a = 4'h0;
      tick(12);
      check("indep_release", 32'(dout_a), 32'h0);

      // Reset while channel 1 is mid-count restarts the filter
      din_a = 4'h2;
      tick(7);
      n_rst = 1'b0;
      tick(1);
      n_rst = 1'b1;
      check("midrst_dout", 32'(dout_a), 32'h0);
      check("midrst_rise", 32'(rise_a), 32'h0);
      check("midrst_dout_b", 32'(dout_b), 32'hF);
      tick(9);
      check("midrst_restart_early", 32'(dout_a), 32'h0);
      tick(1);
      check("midrst_restart_dout", 32'(dout_a), 32'h2);
      check("midrst_restart_rise", 32'(rise_a), 32'h2);
      check("midrst_b_fall_dout", 32'(dout_b), 32'h0);
      check("midrst_b_fall", 32'(fall_b), 32'hF);
      din_a = 4'h0;

      // Inverted instance: active-low press
      din_b = 4'h0;
      tick(9);
      check("inv_press_early", 32'(dout_b), 32'h0);
      tick(1);
      check("inv_press_dout", 32'(dout_b), 32'hF);
      check("inv_press_rise", 32'(rise_b), 32'hF);
      check("inv_no_long", 32'(long_b), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
